// File: rtl/jtopl_wrbus_pkg.sv
// Shared definitions for the OPL CPU write front end.
package jtopl_wrbus_pkg;

    // Register base addresses
    localparam logic [7:0] REG_TEST   = 8'h01;
    localparam logic [7:0] REG_MULT   = 8'h20;
    localparam logic [7:0] REG_KSL_TL = 8'h40;
    localparam logic [7:0] REG_AR_DR  = 8'h60;
    localparam logic [7:0] REG_SL_RR  = 8'h80;
    localparam logic [7:0] REG_FNUMLO = 8'hA0;
    localparam logic [7:0] REG_FNUMHI = 8'hB0;
    localparam logic [7:0] REG_RHY    = 8'hBD;
    localparam logic [7:0] REG_FBCON  = 8'hC0;
    localparam logic [7:0] REG_WAV    = 8'hE0;

    localparam int unsigned SWEEP_LEN = 18;
    localparam int unsigned CNT_W     = 5;

    // Bit positions inside the strobe one-hot
    localparam int unsigned ST_MULT   = 0;
    localparam int unsigned ST_KSL_TL = 1;
    localparam int unsigned ST_AR_DR  = 2;
    localparam int unsigned ST_SL_RR  = 3;
    localparam int unsigned ST_WAV    = 4;
    localparam int unsigned ST_FNUMLO = 5;
    localparam int unsigned ST_FNUMHI = 6;
    localparam int unsigned ST_FBCON  = 7;

    typedef logic [7:0] strobe_t;

    typedef struct packed {
        logic [1:0] group;
        logic [2:0] sub;
        strobe_t    strobe;
    } sel_t;

    typedef struct packed {
        sel_t       sel;
        logic [7:0] data;
    } entry_t;

    typedef struct packed {
        logic valid;
        sel_t sel;
    } dec_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

endpackage

// File: rtl/jtopl_wrbus_if.sv
// CPU bus and register-file update signals of the write front end.
interface jtopl_wrbus_if;
    logic [7:0] din;
    logic       addr;
    logic       cs_n;
    logic       wr_n;
    logic [7:0] reg_din;
    logic       write;
    logic [1:0] sel_group;
    logic [2:0] sel_sub;
    logic       up_mult;
    logic       up_ksl_tl;
    logic       up_ar_dr;
    logic       up_sl_rr;
    logic       up_wav;
    logic       up_fnumlo;
    logic       up_fnumhi;
    logic       up_fbcon;
    logic       rhy_en;
    logic [4:0] rhy_kon;
    logic       wave_mode;
    logic       busy;

    modport master (
        output din, addr, cs_n, wr_n,
        input  reg_din, write, sel_group, sel_sub,
        input  up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav,
        input  up_fnumlo, up_fnumhi, up_fbcon,
        input  rhy_en, rhy_kon, wave_mode, busy
    );

    modport slave (
        input  din, addr, cs_n, wr_n,
        output reg_din, write, sel_group, sel_sub,
        output up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav,
        output up_fnumlo, up_fnumhi, up_fbcon,
        output rhy_en, rhy_kon, wave_mode, busy
    );
endinterface

// File: rtl/jtopl_wrbus_dec.sv
// Combinational decode of the latched register address into group/subslot/strobe.
module jtopl_wrbus_dec
    import jtopl_wrbus_pkg::*;
#(
    parameter bit HAS_WAV = 1'b0
) (
    input  logic [7:0] areg,
    output dec_t       dec
);

    strobe_t    op_strb;
    strobe_t    ch_strb;
    logic [4:0] op;
    logic [3:0] ch;

    assign op = areg[4:0];
    assign ch = areg[3:0];

    // Operator register family from the top three address bits
    always_comb begin
        op_strb = '0;
        if (areg[7:5] == REG_MULT[7:5])
            op_strb[ST_MULT] = 1'b1;
        else if (areg[7:5] == REG_KSL_TL[7:5])
            op_strb[ST_KSL_TL] = 1'b1;
        else if (areg[7:5] == REG_AR_DR[7:5])
            op_strb[ST_AR_DR] = 1'b1;
        else if (areg[7:5] == REG_SL_RR[7:5])
            op_strb[ST_SL_RR] = 1'b1;
        else if (HAS_WAV && (areg[7:5] == REG_WAV[7:5]))
            op_strb[ST_WAV] = 1'b1;
    end

    // Channel register family from the top nibble
    always_comb begin
        ch_strb = '0;
        if (areg[7:4] == REG_FNUMLO[7:4])
            ch_strb[ST_FNUMLO] = 1'b1;
        else if (areg[7:4] == REG_FNUMHI[7:4])
            ch_strb[ST_FNUMHI] = 1'b1;
        else if (areg[7:4] == REG_FBCON[7:4])
            ch_strb[ST_FBCON] = 1'b1;
    end

    // Range checks and selector mapping; holes in the map decode as invalid
    always_comb begin
        dec = '0;
        if ((op_strb != '0) && (op <= 5'h15) && (op[2:0] <= 3'd5)) begin
            dec.valid      = 1'b1;
            dec.sel.group  = op[4:3];
            dec.sel.sub    = op[2:0];
            dec.sel.strobe = op_strb;
        end else if ((ch_strb != '0) && (ch <= 4'd8)) begin
            dec.valid      = 1'b1;
            dec.sel.strobe = ch_strb;
            if (ch < 4'd3) begin
                dec.sel.group = 2'd0;
                dec.sel.sub   = ch[2:0];
            end else if (ch < 4'd6) begin
                dec.sel.group = 2'd1;
                dec.sel.sub   = 3'(ch - 4'd3);
            end else begin
                dec.sel.group = 2'd2;
                dec.sel.sub   = 3'(ch - 4'd6);
            end
        end
    end

endmodule

// File: rtl/jtopl_wrbus.sv
// CPU write front end: bus cycle capture, register decode and 18-slot strobe sweep.
module jtopl_wrbus
    import jtopl_wrbus_pkg::*;
#(
    parameter int unsigned OPL_TYPE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    jtopl_wrbus_if.slave  bus
);

    localparam bit HAS_WAV = (OPL_TYPE != 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SWEEP_LEN - 1);

    logic             wr_n_l;
    logic             wr_ev_c;
    logic [7:0]       areg;
    logic             write;
    entry_t           req;
    logic             req_vld;
    logic             rhy_en;
    logic [4:0]       rhy_kon;
    logic             wave_mode;
    dec_t             dec;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    entry_t           act;
    entry_t           pend;
    logic             pend_vld;
    logic             busy;

    jtopl_wrbus_dec #(.HAS_WAV(HAS_WAV)) u_dec (
        .areg (areg),
        .dec  (dec)
    );

    // Falling edge of wr_n qualified by chip select; a held-low wr_n fires once
    assign wr_ev_c = ~bus.cs_n & ~bus.wr_n & wr_n_l;

    // Bus cycle capture: address latch, write pulse, decoded request, direct registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_n_l    <= 1'b0;
            areg      <= '0;
            write     <= 1'b0;
            req       <= '0;
            req_vld   <= 1'b0;
            rhy_en    <= 1'b0;
            rhy_kon   <= '0;
            wave_mode <= 1'b0;
        end else begin
            wr_n_l  <= bus.wr_n;
            write   <= 1'b0;
            req_vld <= 1'b0;
            if (wr_ev_c) begin
                if (!bus.addr) begin
                    areg <= bus.din;
                end else begin
                    write    <= 1'b1;
                    req.sel  <= dec.sel;
                    req.data <= bus.din;
                    req_vld  <= dec.valid;
                    if (areg == REG_RHY) begin
                        rhy_en  <= bus.din[5];
                        rhy_kon <= bus.din[4:0];
                    end
                    if (HAS_WAV && (areg == REG_TEST))
                        wave_mode <= bus.din[5];
                end
            end
        end
    end

    // Sweep FSM: holds the active strobe for SWEEP_LEN cen pulses, chains the pending entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            act      <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_vld) begin
                        act   <= req;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (cen && (cnt == CNT_LAST)) begin
                        cnt <= '0;
                        if (pend_vld) begin
                            act      <= pend;
                            pend_vld <= req_vld;
                            if (req_vld)
                                pend <= req;
                        end else if (req_vld) begin
                            act <= req;
                        end else begin
                            act.sel.strobe <= '0;
                            busy           <= 1'b0;
                            state          <= IDLE;
                        end
                    end else begin
                        if (cen)
                            cnt <= cnt + 1'b1;
                        if (req_vld) begin
                            pend     <= req;
                            pend_vld <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.reg_din   = act.data;
    assign bus.write     = write;
    assign bus.sel_group = act.sel.group;
    assign bus.sel_sub   = act.sel.sub;
    assign bus.up_mult   = act.sel.strobe[ST_MULT];
    assign bus.up_ksl_tl = act.sel.strobe[ST_KSL_TL];
    assign bus.up_ar_dr  = act.sel.strobe[ST_AR_DR];
    assign bus.up_sl_rr  = act.sel.strobe[ST_SL_RR];
    assign bus.up_wav    = act.sel.strobe[ST_WAV];
    assign bus.up_fnumlo = act.sel.strobe[ST_FNUMLO];
    assign bus.up_fnumhi = act.sel.strobe[ST_FNUMHI];
    assign bus.up_fbcon  = act.sel.strobe[ST_FBCON];
    assign bus.rhy_en    = rhy_en;
    assign bus.rhy_kon   = rhy_kon;
    assign bus.wave_mode = wave_mode;
    assign bus.busy      = busy;

endmodule

// File: doc/jtopl_wrbus.md
# jtopl_wrbus

CPU-side write front end for the OPL register file. It accepts YM3812-style bus cycles: A0=0 latches the register address, and A0=1 writes the data byte. It decodes the register number into a group/subslot selector and one `up_*` strobe. It holds that strobe for one full 18-slot sweep of the slot counter so the register file commits the byte when its slot comes round. A one-deep pending buffer absorbs a write that arrives while a sweep is in progress.

## Interface
Parameters:
- OPL_TYPE, 1, chip variant; when 1, registers 0xE0–0xF5 and 0x01 are ignored and `up_wav`/`wave_mode` stay 0.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cen  in  1  clock enable, one pulse per slot
- din  in  8  CPU data bus
- addr  in  1  A0; 0 = address phase, 1 = data phase
- cs_n  in  1  chip select, active low
- wr_n  in  1  write strobe, active low
- reg_din  out  8  data byte presented to the register file
- write  out  1  one-clk pulse on every accepted data-phase write
- sel_group  out  2  target group 0–2
- sel_sub  out  3  target subslot
- up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav, up_fnumlo, up_fnumhi, up_fbcon  out  1 each  update strobes; at most one is high at a time
- rhy_en  out  1  register 0xBD bit 5
- rhy_kon  out  5  register 0xBD bits 4:0
- wave_mode  out  1  register 0x01 bit 5
- busy  out  1  high while a sweep is in progress or a write is pending

## Operation
- Bus write event: wr_n falling edge while cs_n=0, detected on clk and independent of cen. A held-low wr_n produces a single event.
- Address phase: `areg` <= din. The address phase never affects busy or any strobe.
- Data phase: `write` pulses for one clk. The byte is then decoded against `areg`.
- Operator registers 0x20/0x40/0x60/0x80/0xE0 + o, where o = 0x00–0x15 and o[2:0] ≤ 5:
  - sel_group = o[4:3], sel_sub = o[2:0].
  - Strobe: mult, ksl_tl, ar_dr, sl_rr or wav respectively.
- Channel registers 0xA0/0xB0/0xC0 + n, where n = 0–8:
  - sel_group = n/3, sel_sub = n%3.
  - Strobe: fnumlo, fnumhi or fbcon respectively.
- 0xBD updates rhy_en and rhy_kon on the same clk as `write`.
- 0x01 updates wave_mode on the same clk as `write`.
- Neither 0xBD nor 0x01 starts a sweep.
- Any other address, including o[2:0] = 6 or 7, o > 0x15 or n > 8, is dropped: `write` still pulses, no strobe, busy unchanged.
- FSM:
  - IDLE: on a decoded strobe write, load the selector, strobe and reg_din, clear cnt, and go to SWEEP.
  - SWEEP: strobe held high, cnt increments on each cen. When cnt = 17 and cen, the strobe drops.
    - If the pending buffer is valid, load it and stay in SWEEP with cnt = 0.
    - Otherwise go to IDLE.
- Pending buffer: {selector, strobe, data}, one entry.
  - A strobe write arriving during SWEEP fills it.
  - A further write arriving while it is full overwrites it (last write wins).
- Active reg_din, selector and strobe never change during a sweep.

## Timing
- Reset: all outputs 0; FSM in IDLE; areg = 0; pending invalid.
- `write` is asserted the clk after the wr_n falling edge is seen.
- The strobe and busy rise on the clk following `write`.
- The strobe stays high for exactly 18 cen pulses.
- busy is the OR of (state == SWEEP) and pending valid. It falls on the same clk as the final strobe.
- A data write coinciding with the final SWEEP cen goes to the pending buffer. The next sweep then starts back-to-back with no idle clk.
- A cen gap of any length stretches the sweep without loss.
- Asserting rst mid-sweep aborts it immediately and discards the pending entry.

## Structure
- Shared package: register base addresses (0x01, 0x20, 0x40, 0x60, 0x80, 0xA0, 0xB0, 0xBD, 0xC0, 0xE0), a strobe one-hot typedef (8 bits), and SWEEP_LEN = 18.
- Sub-module jtopl_wrbus_dec: purely combinational address decoder, `areg` → {valid, sel_group, sel_sub, strobe one-hot}.
- The FSM, counter, pending buffer and rhythm registers live in the top level.

## Test plan
- Address 0x43, data 0x3F → sel_group = 0, sel_sub = 3, up_ksl_tl high for exactly 18 cen, reg_din = 0x3F, busy falls with the strobe.
- Address 0xA7, data 0x55 → sel_group = 2, sel_sub = 1, up_fnumlo for 18 cen.
- Address 0xA9 (invalid) → no strobe and busy stays 0. Address 0x26 (invalid) → same.
- Write 0xB0 = 0x12, then 0xB1 = 0x34, then 0xB2 = 0x56, all during the first sweep → the second sweep uses ch2/0x56, the 0x34 write is lost, and there are exactly 36 strobe cen in total.
- Address 0xBD, data 0x3F → rhy_en = 1, rhy_kon = 0x1F on the clk of `write`, busy stays 0. With OPL_TYPE = 1, writing 0x01 = 0x20 leaves wave_mode = 0.
- rst pulsed at cnt = 9 with a pending entry → all outputs 0 and FSM in IDLE; the next write sweeps normally.
